// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings,
// FSM state encoding, counter width and default latencies.
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int CNT_W        = 8;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

endpackage

// File: rtl/md_sched_if.sv
// Issue/result bundle between the E stage and the md scheduler.
// The cancel wire exists only when MD_CANCEL_EN is defined.
interface md_sched_if;
  import md_sched_pkg::*;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        pending;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b,
`ifdef MD_CANCEL_EN
    output cancel,
`endif
    input  busy, pending, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b,
`ifdef MD_CANCEL_EN
    input  cancel,
`endif
    output busy, pending, hi, lo
  );

endinterface

// File: rtl/md_calc.sv
// Purely combinational 64-bit multiply/divide result; wr is low when the
// operation must not touch HI/LO (divide by zero, non-arithmetic ops).
module md_calc
  import md_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        wr
);

  // The INT_MIN / -1 overflow wraps to INT_MIN with a zero remainder.
  function automatic logic [63:0] sdiv(input logic signed [31:0] n,
                                       input logic signed [31:0] d);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (n == 32'sh8000_0000 && d == -32'sd1) begin
      q = n;
      r = '0;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  logic signed [63:0] sa;
  logic signed [63:0] sb;

  always_comb begin
    res = '0;
    wr  = 1'b0;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    case (op)
      MD_MULT: begin
        res = sa * sb;
        wr  = 1'b1;
      end
      MD_MULTU: begin
        res = {32'b0, a} * {32'b0, b};
        wr  = 1'b1;
      end
      MD_DIV: begin
        if (b != '0) begin
          res = sdiv(a, b);
          wr  = 1'b1;
        end
      end
      MD_DIVU: begin
        if (b != '0) begin
          res = {a % b, a / b};
          wr  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle MIPS-style multiply/divide scheduler holding HI/LO.
// Optional abort of an in-flight operation is enabled by MD_CANCEL_EN.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  bus
);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_p0;
  logic [31:0]      a_p0;
  logic [31:0]      b_p0;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [63:0]      calc_res;
  logic             calc_wr;
  logic             abort;
  logic             is_mul;
  logic             is_md;
  logic             issue;

`ifdef MD_CANCEL_EN
  assign abort = bus.cancel;
`else
  assign abort = 1'b0;
`endif

  assign is_mul = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);
  assign is_md  = is_mul || (bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU);
  assign issue  = bus.start && (state == ST_IDLE) && !abort;

  // Operands are captured at issue so later forwarding changes cannot leak in.
  always_ff @(posedge clk) begin
    if (issue && is_md) begin
      op_p0 <= bus.md_op;
      a_p0  <= bus.src_a;
      b_p0  <= bus.src_b;
    end
  end

  md_calc u_calc (
    .op  (op_p0),
    .a   (a_p0),
    .b   (b_p0),
    .res (calc_res),
    .wr  (calc_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state <= ST_IDLE;
        if (calc_wr) begin
          hi <= calc_res[63:32];
          lo <= calc_res[31:0];
        end
      end
    end else if (issue) begin
      if (is_md) begin
        state <= ST_RUN;
        cnt   <= is_mul ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
      end else if (bus.md_op == MD_MTHI) begin
        hi <= bus.src_a;
      end else if (bus.md_op == MD_MTLO) begin
        lo <= bus.src_a;
      end
    end
  end

  assign bus.busy    = (state == ST_RUN);
  assign bus.pending = bus.start || bus.busy;
  assign bus.hi      = hi;
  assign bus.lo      = lo;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO pushed at issue, popped at
// writeback. Cancel scenarios compile in only with MD_CANCEL_EN.
module tb_md_sched;
  import md_sched_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] sb_q[$];

  md_sched_if bus ();

  md_sched #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    longint unsigned ua, ub;
    int qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    qa = $signed(a);
    qb = $signed(b);
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return 64'(ua * ub);
      3'd3: return (b == 0) ? cur : {32'(qa % qb), 32'(qa / qb)};
      3'd4: return (b == 0) ? cur : {a % b, a / b};
      default: return cur;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Issue an md op, count busy cycles, then compare against the scoreboard.
  // With disturb set, an MTHI and changed operands are driven mid-run.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc, input bit disturb);
    logic [63:0] e;
    int n;
    sb_q.push_back(model(op, a, b, {m_hi, m_lo}));
    issue(op, a, b);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      if (disturb && n == 2) begin
        bus.start = 1'b1;
        bus.md_op = MD_MTHI;
        bus.src_a = 32'h0000_AAAA;
        bus.src_b = 32'h0000_5555;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    chk({tag, "_busy_len"}, 64'(n), 64'(ncyc));
    e = sb_q.pop_front();
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, e);
    {m_hi, m_lo} = e;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    bus.src_a = '0;
    bus.src_b = '0;
`ifdef MD_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    m_hi = '0;
    m_lo = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_pending", 64'(bus.pending), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

    // pending follows start combinationally
    bus.start = 1'b1;
    bus.md_op = MD_NONE;
    #1;
    chk("pending_start", 64'(bus.pending), 64'd1);
    tick();
    bus.start = 1'b0;
    chk("none_nop", {55'd0, bus.busy, bus.hi[3:0], bus.lo[3:0]}, 64'd0);

    run_md("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, MC, 1'b0);
    chk("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_md("divu_7_2", MD_DIVU, 32'd7, 32'd2, DC, 1'b0);
    chk("divu_const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
    run_md("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, DC, 1'b0);
    chk("div_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 1'b0);
    chk("multu_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    issue(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo_hilo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;
    run_md("div0", MD_DIV, 32'd100, 32'd0, DC, 1'b0);
    chk("div0_const", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    run_md("divu0", MD_DIVU, 32'd100, 32'd0, DC, 1'b0);

    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    chk("undef_busy", 64'(bus.busy), 64'd0);
    chk("undef_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    run_md("mult_mthi_busy", MD_MULT, 32'h0001_0000, 32'h0003_0000, MC, 1'b1);
    chk("mthi_ignored", 64'(bus.hi), 64'h3);

    for (int i = 0; i < 6; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'(1 + (i % 4));
      a = $urandom;
      b = (i == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
      if (b == 32'hFFFF_FFFF) b = 32'd3;
      run_md("rand", op, a, b, (op <= 3'd2) ? MC : DC, 1'b0);
    end

    // reset in the third busy cycle of a DIV
    issue(MD_DIV, 32'd1000, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_run_busy", 64'(bus.busy), 64'd0);
    chk("rst_run_hilo", {bus.hi, bus.lo}, 64'd0);
    for (int i = 0; i < DC + 2; i++) tick();
    chk("rst_run_nowb", {bus.hi, bus.lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;

`ifdef MD_CANCEL_EN
    issue(MD_MTHI, 32'd1, 32'd0);
    issue(MD_MTLO, 32'd2, 32'd0);
    issue(MD_MULT, 32'd9, 32'd9);
    tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cancel_busy", 64'(bus.busy), 64'd0);
    chk("cancel_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0002);
    bus.cancel = 1'b1;
    issue(MD_MULT, 32'd3, 32'd3);
    bus.cancel = 1'b0;
    chk("cancel_drop_start", 64'(bus.busy), 64'd0);
    for (int i = 0; i < MC + 1; i++) tick();
    chk("cancel_drop_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0002);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
